bnn_fmap_feeder: RTL and testbench

- Turns the per-output-channel bit maps produced by the BNN layer back into a pixel-serial, channel-parallel stream for the next BNN layer.
- Capture side: one channel's full map (108 bits for Conv2, 54 bits for Conv3) per write, stored by channel address.
- Stream side: one pixel per cycle, all CH channels on a CH-bit bus, paced by a hold input.

---
 rtl/bnn_fmap_feeder_pkg.sv | 30 +++
 rtl/bnn_fmap_colsel.sv | 26 ++
 rtl/bnn_fmap_feeder.sv | 170 +++++++++++++++++
 tb/tb_bnn_fmap_feeder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_fmap_feeder_pkg.sv
// Shared constants and types for the BNN feature-map feeder.
// The defaults match the BNN layer parameters (Conv2 / Conv3 map sizes).
package bnn_fmap_feeder_pkg;

  localparam int CH   = 48;
  localparam int BL   = 108;
  localparam int BL_S = 54;
  localparam int AW   = 7;
  localparam int CW   = $clog2(BL);

  localparam logic SEL_CONV2 = 1'b0;
  localparam logic SEL_CONV3 = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Bit index of the first streamed pixel for the selected map size.
  function automatic logic [CW-1:0] first_idx(input logic sel);
    logic [CW-1:0] idx;
    case (sel)
      SEL_CONV2: idx = CW'(BL - 1);
      SEL_CONV3: idx = CW'(BL_S - 1);
      default:   idx = CW'(BL - 1);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/bnn_fmap_colsel.sv
// Column select: picks bit idx from every stored row, giving one pixel of all channels.
module bnn_fmap_colsel
  import bnn_fmap_feeder_pkg::*;
#(
  parameter int ROWS = CH,
  parameter int COLS = BL,
  parameter int IW   = CW
) (
  input  logic [ROWS-1:0][COLS-1:0] rows,
  input  logic [IW-1:0]             idx,
  output logic [ROWS-1:0]           col
);

  // Out-of-range indices read as zero.
  always_comb begin
    col = {ROWS{1'b0}};
    for (int c = 0; c < ROWS; c++) begin
      if (idx < IW'(COLS)) begin
        col[c] = rows[c][idx];
      end else begin
        col[c] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bnn_fmap_feeder.sv
// Captures per-channel bit maps and replays them pixel-serial, channel-parallel.
// Define BNN_FEEDER_PARTIAL_EN to allow streaming from a partially filled store.
module bnn_fmap_feeder
  import bnn_fmap_feeder_pkg::*;
(
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSTART,
  input  logic          iSEL,
  input  logic          iCAP_VALID,
  input  logic [AW-1:0] iCAP_CH,
  input  logic [BL-1:0] iCAP_DATA,
  input  logic          iREQ,
  input  logic          iHOLD,
  output logic [CH-1:0] oDATA,
  output logic          oVALID,
  output logic          oLAST,
  output logic          oFULL,
  output logic          oBUSY,
  output logic          oERR
);

  state_t                state_r, state_n;
  logic [CW-1:0]         cnt_r, cnt_n;
  logic [CH-1:0]         mask_r, mask_n;
  logic [CH-1:0]         data_r, data_n;
  logic                  valid_r, valid_n;
  logic                  last_r, last_n;
  logic                  err_r, err_n;
  logic                  full_r;
  logic                  cap_ok_s, req_ok_s;
  logic [CH-1:0]         cap_onehot_s, col_s;
  logic [CW-1:0]         col_idx_s;
  logic [CH-1:0][BL-1:0] mem_r, rows_s;

  assign cap_ok_s = !iSTART && (state_r == ST_IDLE) && iCAP_VALID && (iCAP_CH < AW'(CH));

`ifdef BNN_FEEDER_PARTIAL_EN
  assign req_ok_s = |mask_r;
`else
  assign req_ok_s = full_r;
`endif

  // On acceptance the first pixel is the top bit of the selected map size.
  assign col_idx_s = (state_r == ST_IDLE) ? first_idx(iSEL) : (cnt_r - CW'(1));

  // Capture decode; a same-edge capture is forwarded so the first pixel sees it.
  always_comb begin
    cap_onehot_s = {CH{1'b0}};
    rows_s       = mem_r;
    for (int c = 0; c < CH; c++) begin
      if (cap_ok_s && (iCAP_CH == AW'(c))) begin
        cap_onehot_s[c] = 1'b1;
        rows_s[c]       = iCAP_DATA;
      end else begin
        cap_onehot_s[c] = 1'b0;
      end
    end
  end

  bnn_fmap_colsel u_colsel (
    .rows (rows_s),
    .idx  (col_idx_s),
    .col  (col_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    mask_n  = mask_r;
    data_n  = data_r;
    valid_n = valid_r;
    last_n  = last_r;
    err_n   = err_r;
    if (iSTART) begin
      state_n = ST_IDLE;
      cnt_n   = {CW{1'b0}};
      mask_n  = {CH{1'b0}};
      data_n  = {CH{1'b0}};
      valid_n = 1'b0;
      last_n  = 1'b0;
      err_n   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (iCAP_VALID && !cap_ok_s) begin
            err_n = 1'b1;
          end else begin
            mask_n = mask_r | cap_onehot_s;
          end
          if (iREQ && req_ok_s) begin
            state_n = ST_STREAM;
            cnt_n   = first_idx(iSEL);
            data_n  = col_s & mask_n;
            valid_n = 1'b1;
            last_n  = (first_idx(iSEL) == {CW{1'b0}});
          end else if (iREQ) begin
            err_n = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_STREAM: begin
          if (iCAP_VALID) begin
            err_n = 1'b1;
          end else begin
            err_n = err_r;
          end
          if (iHOLD) begin
            state_n = ST_STREAM;
          end else if (cnt_r == {CW{1'b0}}) begin
            state_n = ST_IDLE;
            mask_n  = {CH{1'b0}};
            data_n  = {CH{1'b0}};
            valid_n = 1'b0;
            last_n  = 1'b0;
          end else begin
            cnt_n  = cnt_r - CW'(1);
            data_n = col_s & mask_r;
            last_n = (cnt_r == CW'(1));
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      mask_r  <= {CH{1'b0}};
      data_r  <= {CH{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      err_r   <= 1'b0;
      full_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      mask_r  <= mask_n;
      data_r  <= data_n;
      valid_r <= valid_n;
      last_r  <= last_n;
      err_r   <= err_n;
      full_r  <= &mask_n;
    end
  end

  // Map storage keeps its contents across reset.
  always_ff @(posedge iCLK) begin
    for (int c = 0; c < CH; c++) begin
      if (cap_onehot_s[c]) begin
        mem_r[c] <= iCAP_DATA;
      end
    end
  end

  assign oDATA  = data_r;
  assign oVALID = valid_r;
  assign oLAST  = last_r;
  assign oFULL  = full_r;
  assign oBUSY  = (state_r == ST_STREAM);
  assign oERR   = err_r;

endmodule

// File: tb/tb_bnn_fmap_feeder.sv
// Self-checking bench for bnn_fmap_feeder: vector table, directed corner cases and
// randomized maps checked against a row/mask model of the expected pixel stream.
module tb_bnn_fmap_feeder;
  import bnn_fmap_feeder_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          sel = 1'b0;
  logic          cap_valid = 1'b0;
  logic [AW-1:0] cap_ch = '0;
  logic [BL-1:0] cap_data = '0;
  logic          req = 1'b0;
  logic          hold = 1'b0;
  logic [CH-1:0] data;
  logic          valid, last, full, busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BL-1:0] ref_mem [CH];
  logic [CH-1:0] ref_mask = '0;
  logic [CH-1:0] exp_q [$];

  typedef struct {
    int op;   // 0 start, 1 capture, 2 request
    int ch;
    bit e_err;
    bit e_full;
    bit e_valid;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  bnn_fmap_feeder dut (
    .iCLK(clk), .iRST(rst), .iSTART(start), .iSEL(sel),
    .iCAP_VALID(cap_valid), .iCAP_CH(cap_ch), .iCAP_DATA(cap_data),
    .iREQ(req), .iHOLD(hold),
    .oDATA(data), .oVALID(valid), .oLAST(last), .oFULL(full), .oBUSY(busy), .oERR(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [BL-1:0] rnd_row();
    return BL'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  task automatic cap(input int ch, input logic [BL-1:0] d);
    @(negedge clk);
    cap_valid = 1'b1; cap_ch = AW'(ch); cap_data = d;
    @(negedge clk);
    cap_valid = 1'b0;
    if (ch < CH) begin
      ref_mem[ch]  = d;
      ref_mask[ch] = 1'b1;
    end
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ref_mask = '0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < 4; k++) cap($urandom_range(0, CH - 1), rnd_row());
    for (int c = 0; c < CH; c++) cap(c, rnd_row());
  endtask

  // Pixel p carries bit N-1-p of every captured row; missing rows read 0.
  task automatic build_expected(input int n);
    logic [CH-1:0] pix;
    exp_q.delete();
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < CH; c++) pix[c] = ref_mask[c] & ref_mem[c][n - 1 - p];
      exp_q.push_back(pix);
    end
  endtask

  task automatic run_stream(input logic s, input int hold_at, input int hold_len,
                            input int abort_at, input int cap_at);
    int n, i, held, vcyc;
    bit done, capped;
    n = s ? BL_S : BL;
    build_expected(n);
    i = 0; held = 0; vcyc = 0; done = 1'b0; capped = 1'b0;
    @(negedge clk); req = 1'b1; sel = s;
    @(negedge clk); req = 1'b0; sel = ~s;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      hold = 1'b0; cap_valid = 1'b0;
      if (!valid) begin
        done = 1'b1;
      end else if (i >= n) begin
        chk("overrun_pixel", i, n - 1);
        done = 1'b1;
      end else begin
        vcyc++;
        chk($sformatf("pixel%0d", i), data, exp_q[i]);
        chk($sformatf("last%0d", i), last, (i == n - 1));
        chk("busy_in_stream", busy, 1);
        if (i == abort_at) begin
          start = 1'b1;
          @(negedge clk); start = 1'b0;
          chk("abort_valid", valid, 0);
          chk("abort_busy", busy, 0);
          chk("abort_full", full, 0);
          chk("abort_last", last, 0);
          chk("abort_data", data, 0);
          ref_mask = '0;
          return;
        end
        if (i == cap_at && !capped) begin
          cap_valid = 1'b1; cap_ch = AW'(3); cap_data = ~ref_mem[3]; capped = 1'b1;
        end
        if (i == hold_at && held < hold_len) begin
          hold = 1'b1; held++;
        end else begin
          i++;
        end
        @(negedge clk);
      end
    end
    hold = 1'b0; cap_valid = 1'b0;
    chk("stream_ended", done, 1);
    chk("valid_cycles", vcyc, n + hold_len);
    chk("end_busy", busy, 0);
    chk("end_last", last, 0);
    chk("end_full", full, 0);
    chk("end_data", data, 0);
    chk("end_err", err, (cap_at >= 0));
    ref_mask = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [BL-1:0] row;
    tbl[0] = '{0, 0,   0, 0, 0};
    tbl[1] = '{1, 48,  1, 0, 0};
    tbl[2] = '{1, 5,   1, 0, 0};
    tbl[3] = '{0, 0,   0, 0, 0};
    tbl[4] = '{2, 0,   1, 0, 0};
    tbl[5] = '{0, 0,   0, 0, 0};
    tbl[6] = '{1, 127, 1, 0, 0};
    tbl[7] = '{0, 0,   0, 0, 0};
    tbl[8] = '{1, 0,   0, 0, 0};
    tbl[9] = '{1, 0,   0, 0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_last", last, 0);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // Single-cycle control vectors
    for (int k = 0; k < 10; k++) begin
      case (tbl[k].op)
        0: do_start();
        1: cap(tbl[k].ch, rnd_row());
        2: begin
          @(negedge clk); req = 1'b1;
          @(negedge clk); req = 1'b0;
        end
        default: @(negedge clk);
      endcase
      chk($sformatf("vec%0d_err", k), err, tbl[k].e_err);
      chk($sformatf("vec%0d_full", k), full, tbl[k].e_full);
      chk($sformatf("vec%0d_valid", k), valid, tbl[k].e_valid);
    end
    do_start();

    // Conv2 fill pattern: top bit set, bit 0 = channel parity
    for (int c = 0; c < CH; c++) begin
      row = '0; row[BL-1] = 1'b1; row[0] = (c % 2 == 1);
      cap(c, row);
    end
    chk("full_after_fill", full, 1);
    run_stream(SEL_CONV2, -1, 0, -1, -1);

    // Conv3: only bit 53 set, random junk above the map
    for (int c = 0; c < CH; c++) begin
      row = rnd_row(); row[BL_S-1:0] = '0; row[BL_S-1] = 1'b1;
      cap(c, row);
    end
    run_stream(SEL_CONV3, -1, 0, -1, -1);

    // Hold at pixel 10 for 5 cycles
    fill_random();
    run_stream(SEL_CONV2, 10, 5, -1, -1);

    // Capture during stream is dropped and flagged
    fill_random();
    run_stream(SEL_CONV2, -1, 0, -1, 5);
    do_start();
    chk("err_cleared_by_start", err, 0);

    // Request with 47 channels captured
    for (int c = 0; c < CH - 1; c++) cap(c, rnd_row());
`ifdef BNN_FEEDER_PARTIAL_EN
    run_stream(SEL_CONV2, -1, 0, -1, -1);
`else
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    chk("partial_valid", valid, 0);
    chk("partial_busy", busy, 0);
    chk("partial_err", err, 1);
    cap(CH - 1, rnd_row());
    chk("full_after_last_ch", full, 1);
`endif
    do_start();

    // Synchronous abort at pixel 20
    fill_random();
    run_stream(SEL_CONV2, -1, 0, 20, -1);

    // Asynchronous reset mid-stream
    fill_random();
    @(negedge clk); req = 1'b1; sel = SEL_CONV2;
    @(negedge clk); req = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_full", full, 0);
    chk("arst_last", last, 0);
    chk("arst_data", data, 0);
    @(negedge clk); rst = 1'b0;
    ref_mask = '0;

    // Randomized maps, size and hold position
    for (int it = 0; it < 4; it++) begin
      logic s;
      int hl;
      do_start();
      fill_random();
      s  = 1'($urandom_range(0, 1));
      hl = $urandom_range(0, 3);
      run_stream(s, $urandom_range(0, (s ? BL_S : BL) - 1), hl, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
